// File: rtl/dac_pkg.sv
// Shared constants and types for the DAC waveform playback controller.
package dac_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_DIV    = 2'd1;
   localparam logic [1:0] REG_WAVE   = 2'd2;
   localparam logic [1:0] REG_CYCLES = 2'd3;

   localparam int CTRL_RUN_BIT    = 0;
   localparam int CTRL_SINGLE_BIT = 1;

   localparam int TABLE_LEN_DEF = 98;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/dac_tick_div.sv
// Sample-rate divider: emits one tick every div+1 cycles while not held in clear.
module dac_tick_div #(
   parameter int DIV_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   assign tick = !clear && (cnt == div);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dac_wave_ctrl.sv
// DAC waveform playback sequencer: config registers, period-boundary shadows,
// ROM address/enable generation and sample-valid alignment.
//
//   state | meaning
//   IDLE  | no playback, index and divider held at 0, waiting for CTRL.run
//   RUN   | stepping through the active table, shadows reload at each wrap
module dac_wave_ctrl
   import dac_pkg::*;
#(
   parameter int IDX_W     = 7,
   parameter int WAVE_W    = 2,
   parameter int TABLE_LEN = TABLE_LEN_DEF,
   parameter int DIV_W     = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_wr,
   input  logic [1:0]              cfg_addr,
   input  logic [15:0]             cfg_wdata,
   output logic [WAVE_W+IDX_W-1:0] rd_addr,
   output logic                    rd_en,
   output logic                    sample_valid,
   output logic                    running,
   output logic                    done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_LEN - 1);

   logic              ctrl_run;
   logic              ctrl_single;
   logic [DIV_W-1:0]  div_reg;
   logic [WAVE_W-1:0] wave_reg;
   logic [7:0]        cyc_reg;

   state_t            state;
   logic [IDX_W-1:0]  index;
   logic [DIV_W-1:0]  div_act;
   logic [WAVE_W-1:0] wave_act;
   logic [7:0]        cyc_left;

   logic              tick;
   logic              period_end;
   logic              single_end;
   logic              stop_now;
   logic [7:0]        cyc_eff;
   logic              cfg_unused;

   assign cfg_unused = ^cfg_wdata[15:DIV_W];

   assign period_end = tick && (index == LAST_IDX);
   assign single_end = period_end && ctrl_single && (cyc_left == 8'd1);
   assign stop_now   = period_end && (!ctrl_run || single_end);
   assign cyc_eff    = (cyc_reg == 8'd0) ? 8'd1 : cyc_reg;

   assign running = (state == RUN);
   assign rd_en   = (state == RUN);
   assign rd_addr = {wave_act, index};

   dac_tick_div #(.DIV_W(DIV_W)) u_tick_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state == IDLE),
      .div   (div_act),
      .tick  (tick)
   );

   // The single-shot completion clear is placed last so it overrides a CTRL write in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_run    <= 1'b0;
         ctrl_single <= 1'b0;
         div_reg     <= '0;
         wave_reg    <= '0;
         cyc_reg     <= '0;
      end else begin
         if (cfg_wr) begin
            case (cfg_addr)
               REG_CTRL: begin
                  ctrl_run    <= cfg_wdata[CTRL_RUN_BIT];
                  ctrl_single <= cfg_wdata[CTRL_SINGLE_BIT];
               end
               REG_DIV:  div_reg  <= cfg_wdata[DIV_W-1:0];
               REG_WAVE: wave_reg <= cfg_wdata[WAVE_W-1:0];
               default:  cyc_reg  <= cfg_wdata[7:0];
            endcase
         end
         if (single_end) begin
            ctrl_run <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         index        <= '0;
         div_act      <= '0;
         wave_act     <= '0;
         cyc_left     <= '0;
         done         <= 1'b0;
         sample_valid <= 1'b0;
      end else begin
         done         <= 1'b0;
         sample_valid <= (state == RUN);
         case (state)
            IDLE: begin
               index <= '0;
               if (ctrl_run) begin
                  state    <= RUN;
                  div_act  <= div_reg;
                  wave_act <= wave_reg;
                  cyc_left <= cyc_eff;
               end
            end
            default: begin
               if (period_end) begin
                  index    <= '0;
                  div_act  <= div_reg;
                  wave_act <= wave_reg;
                  cyc_left <= ctrl_single ? (cyc_left - 8'd1) : cyc_eff;
                  if (stop_now) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end else if (tick) begin
                  index <= index + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dac_wave_ctrl.sv
// Self-checking bench for dac_wave_ctrl: position-based playback model plus directed and random stimulus.
module tb_dac_wave_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [1:0]  cfg_addr = 2'd0;
   logic [15:0] cfg_wdata = 16'd0;
   logic [8:0]  rd_addr;
   logic        rd_en;
   logic        sample_valid;
   logic        running;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dac_wave_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_wr       (cfg_wr),
      .cfg_addr     (cfg_addr),
      .cfg_wdata    (cfg_wdata),
      .rd_addr      (rd_addr),
      .rd_en        (rd_en),
      .sample_valid (sample_valid),
      .running      (running),
      .done         (done)
   );

   // Model tracks the position (in clocks) inside the current period; index is derived by division.
   typedef struct packed {
      logic run;
      logic single;
      int   div;
      int   wave;
      int   cyc;
      logic play;
      int   pos;
      int   a_div;
      int   a_wave;
      int   a_left;
      logic done;
      logic sv;
   } model_t;

   model_t m;

   function automatic model_t model_next(model_t c, logic wr, logic [1:0] a, logic [15:0] d);
      model_t n = c;
      int     plen;
      bit     hw_clear = 1'b0;
      n.sv   = c.play;
      n.done = 1'b0;
      if (!c.play) begin
         if (c.run) begin
            n.play   = 1'b1;
            n.pos    = 0;
            n.a_div  = c.div;
            n.a_wave = c.wave;
            n.a_left = (c.cyc == 0) ? 1 : c.cyc;
         end
      end else begin
         plen = (c.a_div + 1) * 98;
         if (c.pos == plen - 1) begin
            n.pos    = 0;
            hw_clear = c.single && (c.a_left == 1);
            if (!c.run || hw_clear) begin
               n.play = 1'b0;
               n.done = 1'b1;
            end else begin
               n.a_div  = c.div;
               n.a_wave = c.wave;
               n.a_left = c.single ? c.a_left - 1 : ((c.cyc == 0) ? 1 : c.cyc);
            end
         end else begin
            n.pos = c.pos + 1;
         end
      end
      if (wr) begin
         case (a)
            2'd0: begin n.run = d[0]; n.single = d[1]; end
            2'd1: n.div  = int'(d[9:0]);
            2'd2: n.wave = int'(d[1:0]);
            default: n.cyc = int'(d[7:0]);
         endcase
      end
      if (hw_clear) n.run = 1'b0;
      return n;
   endfunction

   function automatic int exp_addr(model_t x);
      return x.a_wave * 128 + x.pos / (x.a_div + 1);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= model_next(m, cfg_wr, cfg_addr, cfg_wdata);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("rd_en", rd_en, m.play);
         check("running", running, m.play);
         check("sample_valid", sample_valid, m.sv);
         check("done", done, m.done);
         if (m.play) check("rd_addr", rd_addr, exp_addr(m));
      end
   end

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      cfg_addr  = a;
      cfg_wdata = d;
      cfg_wr    = 1'b1;
      @(negedge clk);
      cfg_wr    = 1'b0;
   endtask

   task automatic wait_addr(input int target, input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (rd_en && rd_addr == 9'(target)) return;
      end
      check("wait_addr_timeout", 0, 1);
   endtask

   task automatic wait_done(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done) return;
      end
      check("wait_done_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (!running) return;
      end
      check("wait_idle_timeout", 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_change, period, prev, last, cnt_en, cnt_done;
      bit found;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_rd_addr", rd_addr, 0);
      check("reset_rd_en", rd_en, 0);
      check("reset_sample_valid", sample_valid, 0);
      check("reset_running", running, 0);
      check("reset_done", done, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // DIV=0: one address per clock, start latency and end timing
      wr(2'd1, 16'd0);
      wr(2'd2, 16'd0);
      wr(2'd0, 16'd1);
      check("start_not_yet", rd_en, 0);
      @(negedge clk);
      check("start_rd_en", rd_en, 1);
      check("start_addr", rd_addr, 0);
      check("start_sv_low", sample_valid, 0);
      @(negedge clk);
      check("start_sv_high", sample_valid, 1);
      check("step_addr1", rd_addr, 1);
      for (int k = 2; k <= 98; k++) begin
         @(negedge clk);
         check("step_addr", rd_addr, k % 98);
      end
      wr(2'd0, 16'd0);
      wait_done(300);
      check("end_rd_en", rd_en, 0);
      check("end_running", running, 0);
      check("end_sv_still", sample_valid, 1);
      @(negedge clk);
      check("end_sv_fall", sample_valid, 0);
      check("end_done_one", done, 0);

      // DIV=2: hold 3 clocks, period 294
      wr(2'd1, 16'd2);
      wr(2'd0, 16'd1);
      wait_addr(0, 10);
      first_change = 0;
      period = 0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (rd_addr != 9'd0 && first_change == 0) first_change = c;
         if (rd_addr == 9'd0 && first_change != 0) begin
            period = c;
            break;
         end
      end
      check("div2_hold", first_change, 3);
      check("div2_period", period, 294);
      wr(2'd1, 16'd0);
      wr(2'd0, 16'd0);
      wait_done(400);

      // WAVE switch mid-period takes effect at the wrap
      wr(2'd0, 16'd1);
      wait_addr(40, 300);
      wr(2'd2, 16'd1);
      found = 1'b0;
      prev  = 0;
      for (int i = 0; i < 200; i++) begin
         prev = int'(rd_addr);
         @(negedge clk);
         if (rd_addr == 9'd128) begin
            found = 1'b1;
            break;
         end
      end
      check("wave_switch_seen", found, 1);
      check("wave_switch_prev", prev, 97);
      wr(2'd0, 16'd0);
      wait_done(300);
      wr(2'd2, 16'd0);

      // Single-shot, CYCLES=2
      wr(2'd3, 16'd2);
      wr(2'd0, 16'd3);
      cnt_en = 0;
      cnt_done = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (rd_en) cnt_en++;
         if (done) cnt_done++;
      end
      check("single_rd_en_cycles", cnt_en, 196);
      check("single_done_pulses", cnt_done, 1);
      check("single_run_cleared", running, 0);

      // Graceful stop at index 10
      wr(2'd0, 16'd1);
      wait_addr(10, 200);
      wr(2'd0, 16'd0);
      last = 0;
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done) begin
            found = 1'b1;
            break;
         end
         if (rd_en) last = int'(rd_addr);
      end
      check("stop_done_seen", found, 1);
      check("stop_last_addr", last, 97);

      // Stop cancelled before the wrap
      wr(2'd0, 16'd1);
      wait_addr(10, 200);
      wr(2'd0, 16'd0);
      wait_addr(20, 50);
      wr(2'd0, 16'd1);
      cnt_done = 0;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (done) cnt_done++;
      end
      check("cancel_no_done", cnt_done, 0);
      check("cancel_still_running", running, 1);
      wr(2'd0, 16'd0);
      wait_done(300);

      // Randomized register traffic checked against the model
      for (int it = 0; it < 400; it++) begin
         logic [1:0]  a;
         logic [15:0] d;
         a = 2'($urandom_range(0, 3));
         d = 16'($urandom);
         if (a == 2'd1) d = 16'($urandom_range(0, 3)) | (d & 16'hFC00);
         if (a == 2'd3) d = 16'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) wr(a, d);
         repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      wr(2'd0, 16'd0);
      wait_idle(1000);

      // Reset mid-run
      wr(2'd2, 16'd1);
      wr(2'd1, 16'd3);
      wr(2'd0, 16'd1);
      repeat (20) @(negedge clk);
      check("midrun_running", running, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrun_rd_addr", rd_addr, 0);
      check("midrun_rd_en", rd_en, 0);
      check("midrun_sv", sample_valid, 0);
      check("midrun_running0", running, 0);
      check("midrun_done", done, 0);
      @(negedge clk);
      check("midrun_no_done", done, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_reset_idle", running, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
